// File: rtl/printf_dec_pkg.sv
// Shared constants, FSM state and byte classifier for the ASCII decimal field parser.
package printf_dec_pkg;

   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      DIGITS,
      SKIP
   } state_t;

   typedef enum logic [1:0] {
      DIGIT,
      DELIM,
      ILLEGAL
   } char_class_t;

   function automatic char_class_t classify(input logic [7:0] ch);
      char_class_t cls;
      if (ch >= CH_0 && ch <= CH_9) begin
         cls = DIGIT;
      end else if (ch == CH_SP || ch == CH_COMMA || ch == CH_CR || ch == CH_LF) begin
         cls = DELIM;
      end else begin
         cls = ILLEGAL;
      end
      return cls;
   endfunction

endpackage

// File: rtl/printf_dec_mac.sv
// Decimal multiply-accumulate: next = acc*10 + digit, saturating to all ones.
module printf_dec_mac #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [3:0]       digit,
   output logic [WIDTH-1:0] next,
   output logic             ovf
);

   localparam logic [2*WIDTH-1:0] TEN = (2*WIDTH)'(10);

   logic [2*WIDTH-1:0] wide;

   // Full double-width result so any carry past WIDTH is visible.
   assign wide = ({{WIDTH{1'b0}}, acc} * TEN) + {{(2*WIDTH-4){1'b0}}, digit};
   assign ovf  = |wide[2*WIDTH-1:WIDTH];
   assign next = ovf ? '1 : wide[WIDTH-1:0];

endmodule

// File: rtl/printf_dec_parser.sv
// ASCII unsigned decimal field parser with a single-entry valid/ready output register.
module printf_dec_parser
   import printf_dec_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             out_overflow,
   output logic             out_error,
   output logic             out_line_end
);

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic             ovf, ovf_n;
   logic [WIDTH-1:0] mac_acc, mac_next;
   logic             mac_ovf;
   logic             accept;
   char_class_t      cls;

   logic             load;
   logic [WIDTH-1:0] ld_value;
   logic             ld_ovf, ld_err, ld_le;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign cls      = classify(in_data);

   // First digit of a field reuses the MAC with a zero accumulator.
   assign mac_acc  = (state == DIGITS) ? acc : '0;

   printf_dec_mac #(.WIDTH(WIDTH)) u_mac (
      .acc   (mac_acc),
      .digit (in_data[3:0]),
      .next  (mac_next),
      .ovf   (mac_ovf)
   );

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      ovf_n    = ovf;
      load     = 1'b0;
      ld_value = '0;
      ld_ovf   = 1'b0;
      ld_err   = 1'b0;
      ld_le    = 1'b0;
      if (accept) begin
         unique case (state)
            IDLE: begin
               if (cls == DIGIT) begin
                  acc_n   = mac_next;
                  ovf_n   = 1'b0;
                  state_n = DIGITS;
               end else if (cls == ILLEGAL) begin
                  state_n = SKIP;
               end
            end
            DIGITS: begin
               if (cls == DIGIT) begin
                  acc_n = mac_next;
                  ovf_n = ovf | mac_ovf;
               end else if (cls == DELIM) begin
                  load     = 1'b1;
                  ld_value = acc;
                  ld_ovf   = ovf;
                  ld_le    = (in_data == CH_LF);
                  acc_n    = '0;
                  ovf_n    = 1'b0;
                  state_n  = IDLE;
               end else begin
                  acc_n   = '0;
                  ovf_n   = 1'b0;
                  state_n = SKIP;
               end
            end
            SKIP: begin
               if (cls == DELIM) begin
                  load    = 1'b1;
                  ld_err  = 1'b1;
                  ld_le   = (in_data == CH_LF);
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         acc   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         ovf   <= ovf_n;
      end
   end

   // A load in the same cycle as a pop overwrites the departing field.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_value    <= '0;
         out_overflow <= 1'b0;
         out_error    <= 1'b0;
         out_line_end <= 1'b0;
      end else if (load) begin
         out_valid    <= 1'b1;
         out_value    <= ld_value;
         out_overflow <= ld_ovf;
         out_error    <= ld_err;
         out_line_end <= ld_le;
      end else if (out_valid && out_ready) begin
         out_valid    <= 1'b0;
         out_value    <= '0;
         out_overflow <= 1'b0;
         out_error    <= 1'b0;
         out_line_end <= 1'b0;
      end
   end

endmodule

// File: tb/tb_printf_dec_parser.sv
// Scoreboard bench for printf_dec_parser: directed strings, queued expectations, negedge monitor.
module tb_printf_dec_parser;

   localparam int unsigned WIDTH = 32;

   typedef struct packed {
      logic [WIDTH-1:0] value;
      logic             ovf;
      logic             err;
      logic             le;
   } field_t;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_data = 8'h00;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_value;
   logic             out_overflow;
   logic             out_error;
   logic             out_line_end;

   int unsigned checks = 0;
   int unsigned errors = 0;
   field_t      expq[$];

   printf_dec_parser #(.WIDTH(WIDTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_value    (out_value),
      .out_overflow (out_overflow),
      .out_error    (out_error),
      .out_line_end (out_line_end)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_field(input logic [WIDTH-1:0] v, input logic o, input logic e, input logic l);
      field_t f;
      f.value = v;
      f.ovf   = o;
      f.err   = e;
      f.le    = l;
      expq.push_back(f);
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte was accepted.
   task automatic send(input logic [7:0] b);
      int unsigned n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      forever begin
         @(negedge clock);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            check("send_timeout", 64'(n), 64'(0));
            break;
         end
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   // Monitor: every handshake must match the head of the expectation queue.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            check("unexpected_field", 64'(out_value), 64'(0));
         end else begin
            field_t f;
            f = expq.pop_front();
            check("field_value",    64'(out_value),    64'(f.value));
            check("field_overflow", 64'(out_overflow), 64'(f.ovf));
            check("field_error",    64'(out_error),    64'(f.err));
            check("field_line_end", 64'(out_line_end), 64'(f.le));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_value", 64'(out_value), 64'(0));
      check("rst_flags", 64'({out_overflow, out_error, out_line_end}), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // "123\n": latency and basic decode
      expect_field(32'd123, 1'b0, 1'b0, 1'b1);
      send_str("123");
      check("latency_before_lf", 64'(out_valid), 64'(0));
      send(8'h0A);
      check("latency_after_lf", 64'(out_valid), 64'(1));
      repeat (3) @(posedge clock);
      #1;

      // Maximum value and overflow
      expect_field(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      expect_field(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      send_str("4294967295 4294967296,");

      // Illegal character, then normal field; leading zeros; '-' illegal
      expect_field(32'd0, 1'b0, 1'b1, 1'b0);
      expect_field(32'd7, 1'b0, 1'b0, 1'b1);
      send_str("12a4,7\n");
      expect_field(32'd7, 1'b0, 1'b0, 1'b0);
      expect_field(32'd0, 1'b0, 1'b1, 1'b1);
      send_str("007\r-5\n");
      repeat (3) @(posedge clock);
      #1;

      // Delimiters only: no fields, in_ready always 1
      begin
         string s;
         s = "  ,\r\n";
         for (int i = 0; i < s.len(); i++) begin
            check("delim_in_ready", 64'(in_ready), 64'(1));
            send(s[i]);
         end
      end
      repeat (2) @(posedge clock);
      #1;
      check("delim_no_output", 64'(out_valid), 64'(0));

      // Backpressure: "5 6 " with out_ready low
      out_ready = 1'b0;
      expect_field(32'd5, 1'b0, 1'b0, 1'b0);
      expect_field(32'd6, 1'b0, 1'b0, 1'b0);
      send_str("5 ");
      check("stall_in_ready", 64'(in_ready), 64'(0));
      fork
         send_str("6 ");
         begin
            repeat (3) @(posedge clock);
            #1;
            check("stall_hold_valid", 64'(out_valid), 64'(1));
            check("stall_hold_value", 64'(out_value), 64'(5));
            check("stall_in_ready_held", 64'(in_ready), 64'(0));
            out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clock);
      #1;

      // Reset mid-field
      send_str("98");
      reset = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_out_value", 64'(out_value), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      expect_field(32'd7, 1'b0, 1'b0, 1'b1);
      send_str("7\n");
      repeat (4) @(posedge clock);
      #1;

      check("scoreboard_drained", 64'(expq.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
